// File: rtl/alert_arbiter.sv
// Latches alarm / timer / chime requests and grants the shared piezo and LED
// annunciators to one source at a time, with timed alerts, acknowledge and snooze.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | no alert sounding, no snooze pending; grants pending sources
// ST_ALERT  | one source owns the annunciators; snooze may still be running
// ST_SNOOZE | alarm snoozed, annunciators off; timer/chime may still be granted
module alert_arbiter #(
    parameter int TICK_DIV     = 10000,
    parameter int ALARM_TICKS  = 6000,
    parameter int TIMER_TICKS  = 1000,
    parameter int CHIME_TICKS  = 50,
    parameter int BEEP_TICKS   = 25,
    parameter int SNOOZE_TICKS = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alert_en,
    input  logic       alarm_req,
    input  logic       timer_req,
    input  logic       chime_req,
    input  logic       ack_btn,
    input  logic       snooze_btn,
    output logic       piezo_on,
    output logic       led_activate,
    output logic [1:0] active_src,
    output logic       snoozing
);

    localparam int DUR_MAX = (ALARM_TICKS > TIMER_TICKS)
                           ? ((ALARM_TICKS > CHIME_TICKS) ? ALARM_TICKS : CHIME_TICKS)
                           : ((TIMER_TICKS > CHIME_TICKS) ? TIMER_TICKS : CHIME_TICKS);
    localparam int PRE_W  = $clog2(TICK_DIV + 1);
    localparam int DUR_W  = $clog2(DUR_MAX + 1);
    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_TICKS + 1);

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CHIME = 2'd1;
    localparam logic [1:0] SRC_TIMER = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALERT  = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
    logic                pend_a_q, pend_a_d;
    logic                pend_t_q, pend_t_d;
    logic                pend_c_q, pend_c_d;
    logic [4:0]          in_q, in_d;
    logic                armed_q, armed_d;
    logic                piezo_q, piezo_d;
    logic                led_q, led_d;
    logic [1:0]          active_src_q, active_src_d;
    logic                snoozing_q, snoozing_d;

    logic [4:0] in_vec, rise;
    logic       rise_a, rise_t, rise_c, rise_ack, rise_snz;
    logic       tick, alerting, restart, snz_cancel;
    logic       grant, go_idle;
    logic [1:0] best_src, grant_src;

    function automatic logic [DUR_W-1:0] dur_load(input logic [1:0] src);
        case (src)
            SRC_ALARM: return DUR_W'(ALARM_TICKS);
            SRC_TIMER: return DUR_W'(TIMER_TICKS);
            SRC_CHIME: return DUR_W'(CHIME_TICKS);
            default:   return '0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        dur_cnt_d    = dur_cnt_q;
        beep_cnt_d   = beep_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        pend_a_d     = pend_a_q;
        pend_t_d     = pend_t_q;
        pend_c_d     = pend_c_q;
        piezo_d      = piezo_q;
        led_d        = led_q;
        active_src_d = active_src_q;
        snoozing_d   = snoozing_q;
        grant        = 1'b0;
        grant_src    = SRC_NONE;
        go_idle      = 1'b0;

        // Edges are ignored on the first clock after reset so levels held
        // through reset do not look like fresh requests.
        in_vec   = {snooze_btn, ack_btn, chime_req, timer_req, alarm_req};
        in_d     = in_vec;
        armed_d  = 1'b1;
        rise     = in_vec & ~in_q & {5{armed_q}};
        rise_a   = rise[0];
        rise_t   = rise[1];
        rise_c   = rise[2];
        rise_ack = rise[3];
        rise_snz = rise[4];

        tick      = (pre_cnt_q == PRE_W'(TICK_DIV - 1));
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

        alerting = (state_q == ST_ALERT);
        restart  = alerting && ((rise_a && active_src_q == SRC_ALARM) ||
                                (rise_t && active_src_q == SRC_TIMER) ||
                                (rise_c && active_src_q == SRC_CHIME));

        if (rise_a && !(alerting && active_src_q == SRC_ALARM)) pend_a_d = 1'b1;
        if (rise_t && !(alerting && active_src_q == SRC_TIMER)) pend_t_d = 1'b1;
        if (rise_c && !(alerting && active_src_q == SRC_CHIME)) pend_c_d = 1'b1;

        best_src = pend_a_q ? SRC_ALARM :
                   pend_t_q ? SRC_TIMER :
                   pend_c_q ? SRC_CHIME : SRC_NONE;

        snz_cancel = (state_q == ST_SNOOZE) && rise_ack;
        if (snz_cancel) begin
            snoozing_d = 1'b0;
            snz_cnt_d  = '0;
        end else if (snoozing_q && tick) begin
            if (snz_cnt_q <= SNZ_W'(1)) begin
                snz_cnt_d  = '0;
                snoozing_d = 1'b0;
                pend_a_d   = 1'b1;
            end else begin
                snz_cnt_d = snz_cnt_q - SNZ_W'(1);
            end
        end

        case (state_q)
            ST_ALERT: begin
                if (rise_ack) begin
                    go_idle = 1'b1;
                end else if (rise_snz) begin
                    if (active_src_q == SRC_ALARM) begin
                        state_d      = ST_SNOOZE;
                        snoozing_d   = 1'b1;
                        snz_cnt_d    = SNZ_W'(SNOOZE_TICKS);
                        pre_cnt_d    = '0;
                        piezo_d      = 1'b0;
                        led_d        = 1'b0;
                        active_src_d = SRC_NONE;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (best_src > active_src_q) begin
                    grant     = 1'b1;
                    grant_src = best_src;
                end else if (tick && dur_cnt_q <= DUR_W'(1)) begin
                    go_idle = 1'b1;
                end else begin
                    if (tick) begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                        if (beep_cnt_q == BEEP_W'(BEEP_TICKS - 1)) begin
                            beep_cnt_d = '0;
                            piezo_d    = ~piezo_q;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                        end
                    end
                    if (restart) dur_cnt_d = dur_load(active_src_q);
                end
            end
            default: begin
                if (alert_en && best_src != SRC_NONE) begin
                    grant     = 1'b1;
                    grant_src = best_src;
                end else begin
                    state_d = snoozing_d ? ST_SNOOZE : ST_IDLE;
                end
            end
        endcase

        if (go_idle) begin
            state_d      = snoozing_d ? ST_SNOOZE : ST_IDLE;
            piezo_d      = 1'b0;
            led_d        = 1'b0;
            active_src_d = SRC_NONE;
        end

        // Prescaler restarts on grant so alert length and beep cadence are exact.
        if (grant) begin
            state_d      = ST_ALERT;
            active_src_d = grant_src;
            piezo_d      = 1'b1;
            led_d        = 1'b1;
            dur_cnt_d    = dur_load(grant_src);
            beep_cnt_d   = '0;
            pre_cnt_d    = '0;
            case (grant_src)
                SRC_ALARM: pend_a_d = 1'b0;
                SRC_TIMER: pend_t_d = 1'b0;
                SRC_CHIME: pend_c_d = 1'b0;
                default:   ;
            endcase
        end

        if (!alert_en) begin
            pend_a_d     = 1'b0;
            pend_t_d     = 1'b0;
            pend_c_d     = 1'b0;
            snoozing_d   = 1'b0;
            snz_cnt_d    = '0;
            state_d      = ST_IDLE;
            piezo_d      = 1'b0;
            led_d        = 1'b0;
            active_src_d = SRC_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            dur_cnt_q    <= '0;
            beep_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            pend_a_q     <= 1'b0;
            pend_t_q     <= 1'b0;
            pend_c_q     <= 1'b0;
            in_q         <= '0;
            armed_q      <= 1'b0;
            piezo_q      <= 1'b0;
            led_q        <= 1'b0;
            active_src_q <= SRC_NONE;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            dur_cnt_q    <= dur_cnt_d;
            beep_cnt_q   <= beep_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            pend_a_q     <= pend_a_d;
            pend_t_q     <= pend_t_d;
            pend_c_q     <= pend_c_d;
            in_q         <= in_d;
            armed_q      <= armed_d;
            piezo_q      <= piezo_d;
            led_q        <= led_d;
            active_src_q <= active_src_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign piezo_on     = piezo_q;
    assign led_activate = led_q;
    assign active_src   = active_src_q;
    assign snoozing     = snoozing_q;

endmodule

// File: tb/tb_alert_arbiter.sv
// Directed bench for alert_arbiter with short durations; inputs change and
// outputs are sampled on the falling clock edge.
module tb_alert_arbiter;

    logic       clk;
    logic       rst;
    logic       alert_en;
    logic       alarm_req, timer_req, chime_req;
    logic       ack_btn, snooze_btn;
    logic       piezo_on, led_activate, snoozing;
    logic [1:0] active_src;

    int n_checks = 0;
    int n_errors = 0;

    alert_arbiter #(
        .TICK_DIV    (4),
        .ALARM_TICKS (20),
        .TIMER_TICKS (10),
        .CHIME_TICKS (4),
        .BEEP_TICKS  (2),
        .SNOOZE_TICKS(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alert_en    (alert_en),
        .alarm_req   (alarm_req),
        .timer_req   (timer_req),
        .chime_req   (chime_req),
        .ack_btn     (ack_btn),
        .snooze_btn  (snooze_btn),
        .piezo_on    (piezo_on),
        .led_activate(led_activate),
        .active_src  (active_src),
        .snoozing    (snoozing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        alert_en   = 1'b1;
        alarm_req  = 1'b1;
        timer_req  = 1'b1;
        chime_req  = 1'b1;
        ack_btn    = 1'b0;
        snooze_btn = 1'b0;

        // reset with all requests held high
        wait_clk(3);
        chk("rst_src", active_src, 2'b00);
        chk("rst_piezo", piezo_on, 1'b0);
        chk("rst_led", led_activate, 1'b0);
        chk("rst_snz", snoozing, 1'b0);
        rst = 1'b1;
        wait_clk(3);
        chk("post_rst_src_a", active_src, 2'b00);
        wait_clk(3);
        chk("post_rst_src_b", active_src, 2'b00);
        chk("post_rst_led", led_activate, 1'b0);
        alarm_req = 1'b0;
        timer_req = 1'b0;
        chime_req = 1'b0;
        wait_clk(3);

        // chime alone: 16 clk, piezo toggles after 8
        chime_req = 1'b1;
        wait_clk(1);
        chk("chime_lat", active_src, 2'b00);
        wait_clk(1);
        chk("chime_src", active_src, 2'b01);
        chk("chime_piezo0", piezo_on, 1'b1);
        chk("chime_led", led_activate, 1'b1);
        wait_clk(7);
        chk("chime_piezo7", piezo_on, 1'b1);
        wait_clk(1);
        chk("chime_piezo8", piezo_on, 1'b0);
        chk("chime_src8", active_src, 2'b01);
        wait_clk(7);
        chk("chime_src15", active_src, 2'b01);
        wait_clk(1);
        chk("chime_end_src", active_src, 2'b00);
        chk("chime_end_led", led_activate, 1'b0);
        chk("chime_end_piezo", piezo_on, 1'b0);
        chime_req = 1'b0;
        wait_clk(3);

        // alarm preempts chime, lasts 80 clk, chime is dropped
        chime_req = 1'b1;
        wait_clk(2);
        chk("pre_chime_src", active_src, 2'b01);
        wait_clk(3);
        alarm_req = 1'b1;
        wait_clk(1);
        chk("pre_lat", active_src, 2'b01);
        wait_clk(1);
        chk("pre_alarm_src", active_src, 2'b11);
        chk("pre_alarm_piezo", piezo_on, 1'b1);
        wait_clk(7);
        chk("pre_piezo7", piezo_on, 1'b1);
        wait_clk(1);
        chk("pre_piezo8", piezo_on, 1'b0);
        wait_clk(71);
        chk("pre_alarm79", active_src, 2'b11);
        wait_clk(1);
        chk("pre_alarm80", active_src, 2'b00);
        wait_clk(4);
        chk("pre_no_resume", active_src, 2'b00);
        chk("pre_no_resume_led", led_activate, 1'b0);
        alarm_req = 1'b0;
        chime_req = 1'b0;
        wait_clk(3);

        // simultaneous timer + chime: timer 40 clk, 1 clk gap, chime 16 clk
        timer_req = 1'b1;
        chime_req = 1'b1;
        wait_clk(2);
        chk("sim_timer", active_src, 2'b10);
        wait_clk(39);
        chk("sim_timer39", active_src, 2'b10);
        wait_clk(1);
        chk("sim_gap_src", active_src, 2'b00);
        chk("sim_gap_led", led_activate, 1'b0);
        wait_clk(1);
        chk("sim_chime", active_src, 2'b01);
        chk("sim_chime_piezo", piezo_on, 1'b1);
        wait_clk(15);
        chk("sim_chime15", active_src, 2'b01);
        wait_clk(1);
        chk("sim_chime_end", active_src, 2'b00);
        timer_req = 1'b0;
        chime_req = 1'b0;
        wait_clk(3);

        // snooze on a timer alert acts as acknowledge
        timer_req = 1'b1;
        wait_clk(2);
        chk("tsnz_timer", active_src, 2'b10);
        snooze_btn = 1'b1;
        wait_clk(1);
        chk("tsnz_src", active_src, 2'b00);
        chk("tsnz_snoozing", snoozing, 1'b0);
        snooze_btn = 1'b0;
        timer_req  = 1'b0;
        wait_clk(3);

        // alarm snooze, re-alert after 32 clk, then ack
        alarm_req = 1'b1;
        wait_clk(2);
        chk("snz_alarm", active_src, 2'b11);
        wait_clk(5);
        snooze_btn = 1'b1;
        wait_clk(1);
        chk("snz_src", active_src, 2'b00);
        chk("snz_on", snoozing, 1'b1);
        chk("snz_led", led_activate, 1'b0);
        snooze_btn = 1'b0;
        wait_clk(31);
        chk("snz_on31", snoozing, 1'b1);
        chk("snz_src31", active_src, 2'b00);
        wait_clk(1);
        chk("snz_off32", snoozing, 1'b0);
        chk("snz_src32", active_src, 2'b00);
        wait_clk(1);
        chk("snz_realert", active_src, 2'b11);
        chk("snz_realert_led", led_activate, 1'b1);
        wait_clk(3);
        ack_btn = 1'b1;
        wait_clk(1);
        chk("ack_src", active_src, 2'b00);
        chk("ack_piezo", piezo_on, 1'b0);
        chk("ack_snz", snoozing, 1'b0);
        ack_btn   = 1'b0;
        alarm_req = 1'b0;
        wait_clk(3);

        // abort with timer pending, no grant after re-enable
        alarm_req = 1'b1;
        wait_clk(2);
        chk("abort_alarm", active_src, 2'b11);
        timer_req = 1'b1;
        wait_clk(1);
        chk("abort_no_preempt_a", active_src, 2'b11);
        wait_clk(1);
        chk("abort_no_preempt_b", active_src, 2'b11);
        alert_en = 1'b0;
        wait_clk(1);
        chk("abort_src", active_src, 2'b00);
        chk("abort_piezo", piezo_on, 1'b0);
        chk("abort_led", led_activate, 1'b0);
        wait_clk(2);
        alert_en = 1'b1;
        wait_clk(5);
        chk("abort_no_grant", active_src, 2'b00);
        chk("abort_no_grant_led", led_activate, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
